// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer, reservation stations and branch unit:
// entry type codes, default depth and small decode helpers.
package reorder_buffer_pkg;

    localparam int ROB_SIZE = 8;

    typedef enum logic [1:0] {
        TYPE_REG    = 2'd0,
        TYPE_BRANCH = 2'd1,
        TYPE_JUMP   = 2'd2,
        TYPE_STORE  = 2'd3
    } rob_type_e;

    // Jumps write their link address, so they update the register file like plain ops.
    function automatic logic writes_reg(input rob_type_e t, input logic [4:0] rd);
        return ((t == TYPE_REG) || (t == TYPE_JUMP)) && (rd != 5'd0);
    endfunction

    function automatic logic is_control(input rob_type_e t);
        return (t == TYPE_BRANCH) || (t == TYPE_JUMP);
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates tags at dispatch, collects out-of-order
// results, commits one entry per cycle and flushes on a redirecting branch/jump.
module reorder_buffer #(
    parameter int ROB_SIZE = reorder_buffer_pkg::ROB_SIZE
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        rdy_in,
    input  logic                        alloc_valid_in,
    input  logic [1:0]                  alloc_type_in,
    input  logic [4:0]                  alloc_rd_in,
    input  logic [31:0]                 alloc_pc_in,
    output logic                        alloc_ready_out,
    output logic [$clog2(ROB_SIZE)-1:0] alloc_tag_out,
    input  logic                        wb_valid_in,
    input  logic [$clog2(ROB_SIZE)-1:0] wb_tag_in,
    input  logic [31:0]                 wb_value_in,
    input  logic                        wb_pc_change_in,
    input  logic [31:0]                 wb_new_pc_in,
    output logic                        commit_valid_out,
    output logic [$clog2(ROB_SIZE)-1:0] commit_tag_out,
    output logic [4:0]                  commit_rd_out,
    output logic [31:0]                 commit_value_out,
    output logic                        commit_reg_we_out,
    output logic                        flush_out,
    output logic [31:0]                 redirect_pc_out
);
    import reorder_buffer_pkg::*;

    localparam int TAG_W = $clog2(ROB_SIZE);
    localparam int CNT_W = $clog2(ROB_SIZE + 1);
    localparam logic [TAG_W-1:0] LAST_TAG = TAG_W'(ROB_SIZE - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ROB_SIZE);

    logic [TAG_W-1:0]    head_reg, head_next;
    logic [TAG_W-1:0]    tail_reg, tail_next;
    logic [CNT_W-1:0]    count_reg, count_next;
    logic [ROB_SIZE-1:0] busy_reg, busy_next;
    logic [ROB_SIZE-1:0] ready_reg, ready_next;

    rob_type_e   type_mem      [ROB_SIZE];
    logic [4:0]  rd_mem        [ROB_SIZE];
    logic [31:0] pc_mem        [ROB_SIZE];
    logic [31:0] value_mem     [ROB_SIZE];
    logic        pc_change_mem [ROB_SIZE];
    logic [31:0] new_pc_mem    [ROB_SIZE];

    logic commit_fire, flush_fire, alloc_accept, wb_accept;

    function automatic logic [TAG_W-1:0] bump(input logic [TAG_W-1:0] p);
        return (p == LAST_TAG) ? '0 : p + TAG_W'(1);
    endfunction

    assign commit_fire  = busy_reg[head_reg] && ready_reg[head_reg];
    assign flush_fire   = commit_fire && is_control(type_mem[head_reg]) && pc_change_mem[head_reg];
    // A full buffer refuses allocation even when the head retires in the same cycle.
    assign alloc_accept = alloc_valid_in && (count_reg != FULL_CNT) && !flush_fire;
    assign wb_accept    = wb_valid_in && busy_reg[wb_tag_in] && !flush_fire;

    assign alloc_ready_out = (count_reg < FULL_CNT);
    assign alloc_tag_out   = tail_reg;

    assign head_next  = flush_fire ? '0 : (commit_fire ? bump(head_reg) : head_reg);
    assign tail_next  = flush_fire ? '0 : (alloc_accept ? bump(tail_reg) : tail_reg);
    assign count_next = flush_fire ? '0
                      : count_reg + CNT_W'(alloc_accept) - CNT_W'(commit_fire);

    for (genvar gi = 0; gi < ROB_SIZE; gi++) begin : g_entry
        logic alloc_here, wb_here, clear_here;
        assign alloc_here = alloc_accept && (tail_reg == TAG_W'(gi));
        assign wb_here    = wb_accept && (wb_tag_in == TAG_W'(gi));
        assign clear_here = flush_fire || (commit_fire && (head_reg == TAG_W'(gi)));

        assign busy_next[gi]  = clear_here ? 1'b0 : (alloc_here ? 1'b1 : busy_reg[gi]);
        // Stores have nothing to wait for and are ready from dispatch.
        assign ready_next[gi] = clear_here ? 1'b0
                              : alloc_here ? (alloc_type_in == TYPE_STORE)
                              : wb_here    ? 1'b1
                              : ready_reg[gi];
    end

    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            if (alloc_accept) begin
                type_mem[tail_reg]      <= rob_type_e'(alloc_type_in);
                rd_mem[tail_reg]        <= alloc_rd_in;
                pc_mem[tail_reg]        <= alloc_pc_in;
                value_mem[tail_reg]     <= '0;
                pc_change_mem[tail_reg] <= 1'b0;
                new_pc_mem[tail_reg]    <= '0;
            end
            if (wb_accept) begin
                value_mem[wb_tag_in]     <= wb_value_in;
                pc_change_mem[wb_tag_in] <= wb_pc_change_in;
                new_pc_mem[wb_tag_in]    <= wb_new_pc_in;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_reg          <= '0;
            tail_reg          <= '0;
            count_reg         <= '0;
            busy_reg          <= '0;
            ready_reg         <= '0;
            commit_valid_out  <= 1'b0;
            commit_tag_out    <= '0;
            commit_rd_out     <= '0;
            commit_value_out  <= '0;
            commit_reg_we_out <= 1'b0;
            flush_out         <= 1'b0;
            redirect_pc_out   <= '0;
        end else if (rdy_in) begin
            head_reg         <= head_next;
            tail_reg         <= tail_next;
            count_reg        <= count_next;
            busy_reg         <= busy_next;
            ready_reg        <= ready_next;
            commit_valid_out <= commit_fire;
            flush_out        <= flush_fire;
            if (commit_fire) begin
                commit_tag_out    <= head_reg;
                commit_rd_out     <= rd_mem[head_reg];
                commit_value_out  <= value_mem[head_reg];
                commit_reg_we_out <= writes_reg(type_mem[head_reg], rd_mem[head_reg]);
            end
            if (flush_fire) begin
                redirect_pc_out <= new_pc_mem[head_reg];
            end
        end
    end

    // The PC is kept per entry for debug visibility; retirement itself does not need it.
    logic unused_pc;
    assign unused_pc = ^pc_mem[head_reg];

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus randomized traffic,
// all checked against a queue-based in-order retirement model.
module tb_reorder_buffer;
    localparam int ROB_SIZE = 8;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        alloc_valid_in = 1'b0;
    logic [1:0]  alloc_type_in = '0;
    logic [4:0]  alloc_rd_in = '0;
    logic [31:0] alloc_pc_in = '0;
    logic        alloc_ready_out;
    logic [2:0]  alloc_tag_out;
    logic        wb_valid_in = 1'b0;
    logic [2:0]  wb_tag_in = '0;
    logic [31:0] wb_value_in = '0;
    logic        wb_pc_change_in = 1'b0;
    logic [31:0] wb_new_pc_in = '0;
    logic        commit_valid_out;
    logic [2:0]  commit_tag_out;
    logic [4:0]  commit_rd_out;
    logic [31:0] commit_value_out;
    logic        commit_reg_we_out;
    logic        flush_out;
    logic [31:0] redirect_pc_out;

    reorder_buffer #(.ROB_SIZE(ROB_SIZE)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .alloc_valid_in(alloc_valid_in), .alloc_type_in(alloc_type_in),
        .alloc_rd_in(alloc_rd_in), .alloc_pc_in(alloc_pc_in),
        .alloc_ready_out(alloc_ready_out), .alloc_tag_out(alloc_tag_out),
        .wb_valid_in(wb_valid_in), .wb_tag_in(wb_tag_in), .wb_value_in(wb_value_in),
        .wb_pc_change_in(wb_pc_change_in), .wb_new_pc_in(wb_new_pc_in),
        .commit_valid_out(commit_valid_out), .commit_tag_out(commit_tag_out),
        .commit_rd_out(commit_rd_out), .commit_value_out(commit_value_out),
        .commit_reg_we_out(commit_reg_we_out), .flush_out(flush_out),
        .redirect_pc_out(redirect_pc_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // Reference model: program-order queue of in-flight instructions, front is oldest.
    typedef struct {
        int          tag;
        int          typ;
        int          rd;
        logic [31:0] value;
        bit          rdy;
        bit          pcc;
        logic [31:0] npc;
    } ent_t;

    ent_t        rob_q[$];
    int          m_tail;
    bit          e_valid, e_flush, e_we;
    int          e_tag, e_rd;
    logic [31:0] e_value, e_redirect;

    task automatic model_reset();
        rob_q.delete();
        m_tail = 0;
        e_valid = 0; e_flush = 0; e_we = 0;
        e_tag = 0; e_rd = 0; e_value = '0; e_redirect = '0;
    endtask

    task automatic idle();
        alloc_valid_in = 1'b0;
        wb_valid_in = 1'b0;
        wb_pc_change_in = 1'b0;
    endtask

    task automatic set_alloc(input int typ, input int rd, input logic [31:0] pc);
        alloc_valid_in = 1'b1;
        alloc_type_in = 2'(typ);
        alloc_rd_in = 5'(rd);
        alloc_pc_in = pc;
    endtask

    task automatic set_wb(input int tag, input logic [31:0] val, input bit pcc, input logic [31:0] npc);
        wb_valid_in = 1'b1;
        wb_tag_in = 3'(tag);
        wb_value_in = val;
        wb_pc_change_in = pcc;
        wb_new_pc_in = npc;
    endtask

    // Advance the model by one clock using the current inputs, then clock the DUT.
    task automatic tick();
        ent_t h, e;
        bit commit, fl, was_full;
        if (rdy_in) begin
            commit = (rob_q.size() > 0) && rob_q[0].rdy;
            was_full = (rob_q.size() == ROB_SIZE);
            fl = 1'b0;
            if (commit) begin
                h = rob_q[0];
                e_tag = h.tag;
                e_rd = h.rd;
                e_value = h.value;
                e_we = (h.typ == 0 || h.typ == 2) && h.rd != 0;
                fl = (h.typ == 1 || h.typ == 2) && h.pcc;
                if (fl) e_redirect = h.npc;
            end
            e_valid = commit;
            e_flush = fl;
            if (fl) begin
                rob_q.delete();
                m_tail = 0;
            end else begin
                if (wb_valid_in) begin
                    for (int i = 0; i < rob_q.size(); i++) begin
                        if (rob_q[i].tag == int'(wb_tag_in)) begin
                            e = rob_q[i];
                            e.rdy = 1; e.value = wb_value_in;
                            e.pcc = wb_pc_change_in; e.npc = wb_new_pc_in;
                            rob_q[i] = e;
                        end
                    end
                end
                if (commit) void'(rob_q.pop_front());
                if (alloc_valid_in && !was_full) begin
                    e.tag = m_tail; e.typ = int'(alloc_type_in); e.rd = int'(alloc_rd_in);
                    e.value = '0; e.rdy = (alloc_type_in == 2'd3); e.pcc = 0; e.npc = '0;
                    rob_q.push_back(e);
                    m_tail = (m_tail + 1) % ROB_SIZE;
                end
            end
        end
        @(posedge clk_in);
        #1;
        if (commit_valid_out && rdy_in)
            $display("t=%0t commit tag=%0d rd=%0d value=%h we=%0b flush=%0b redirect=%h",
                     $time, commit_tag_out, commit_rd_out, commit_value_out,
                     commit_reg_we_out, flush_out, redirect_pc_out);
    endtask

    task automatic do_reset();
        idle();
        rdy_in = 1'b1;
        rst_in = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        idle();
        rdy_in = 1'b1;
        rst_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        checks++;
        if ({commit_valid_out, flush_out, commit_reg_we_out} !== 3'b000) begin
            errors++;
            $display("FAIL reset_pulses: got %b expected 000", {commit_valid_out, flush_out, commit_reg_we_out});
        end
        checks++;
        if (commit_tag_out !== 3'd0 || commit_rd_out !== 5'd0 || commit_value_out !== 32'd0 || redirect_pc_out !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: got tag=%0d rd=%0d value=%h redirect=%h expected all 0",
                     commit_tag_out, commit_rd_out, commit_value_out, redirect_pc_out);
        end
        checks++;
        if (alloc_ready_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_alloc_ready: got %b expected 1", alloc_ready_out);
        end
        checks++;
        if (alloc_tag_out !== 3'd0) begin
            errors++;
            $display("FAIL reset_alloc_tag: got %0d expected 0", alloc_tag_out);
        end
        @(negedge clk_in);
        rst_in = 1'b1;
        model_reset();
        tick();
        checks++;
        if (commit_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_commit: got %b expected 0", commit_valid_out);
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < ROB_SIZE; i++) begin
            checks++;
            if (alloc_tag_out !== 3'(i) || alloc_ready_out !== 1'b1) begin
                errors++;
                $display("FAIL fill_tag%0d: got tag=%0d ready=%b expected tag=%0d ready=1", i, alloc_tag_out, alloc_ready_out, i);
            end
            set_alloc(0, i + 1, 32'h100 + 32'(4 * i));
            tick();
        end
        checks++;
        if (alloc_ready_out !== 1'b0) begin
            errors++;
            $display("FAIL fill_full_ready: got %b expected 0", alloc_ready_out);
        end
        tick();
        idle();
        checks++;
        if (alloc_ready_out !== 1'b0 || alloc_tag_out !== 3'd0 || commit_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL fill_ninth_ignored: got ready=%b tag=%0d commit=%b expected 0 0 0", alloc_ready_out, alloc_tag_out, commit_valid_out);
        end
    endtask

    task automatic test_ooo_writeback();
        int order[3] = '{2, 1, 0};
        for (int i = 0; i < 3; i++) begin
            set_wb(order[i], 32'((order[i] + 1) * 16), 1'b0, '0);
            tick();
            checks++;
            if (commit_valid_out !== 1'b0) begin
                errors++;
                $display("FAIL ooo_early_commit%0d: got %b expected 0", i, commit_valid_out);
            end
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (commit_valid_out !== 1'b1 || commit_tag_out !== 3'(i) || commit_value_out !== 32'((i + 1) * 16)
                || commit_rd_out !== 5'(i + 1) || commit_reg_we_out !== 1'b1) begin
                errors++;
                $display("FAIL ooo_commit%0d: got v=%b tag=%0d value=%h rd=%0d we=%b expected 1 %0d %h %0d 1",
                         i, commit_valid_out, commit_tag_out, commit_value_out, commit_rd_out, commit_reg_we_out,
                         i, (i + 1) * 16, i + 1);
            end
        end
        tick();
        checks++;
        if (commit_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL ooo_stop: got %b expected 0", commit_valid_out);
        end
    endtask

    task automatic test_full_commit_alloc();
        for (int i = 0; i < 3; i++) begin
            set_alloc(0, 9, 32'h200);
            tick();
        end
        idle();
        checks++;
        if (alloc_ready_out !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: got %b expected 0", alloc_ready_out);
        end
        set_wb(3, 32'h33, 1'b0, '0);
        tick();
        idle();
        set_alloc(0, 10, 32'h300);
        tick();
        idle();
        checks++;
        if (commit_valid_out !== 1'b1 || commit_tag_out !== 3'd3 || alloc_ready_out !== 1'b1 || alloc_tag_out !== 3'd3) begin
            errors++;
            $display("FAIL full_commit_alloc: got v=%b tag=%0d ready=%b atag=%0d expected 1 3 1 3",
                     commit_valid_out, commit_tag_out, alloc_ready_out, alloc_tag_out);
        end
        set_alloc(0, 11, 32'h304);
        tick();
        idle();
        checks++;
        if (alloc_ready_out !== 1'b0) begin
            errors++;
            $display("FAIL full_count7: got ready=%b expected 0 after one more allocation", alloc_ready_out);
        end
    endtask

    task automatic test_branch_flush();
        int wb_order[7] = '{4, 5, 6, 0, 1, 2, 3};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            set_alloc((i == 3) ? 1 : 0, i + 1, 32'h400 + 32'(4 * i));
            tick();
        end
        idle();
        for (int i = 0; i < 7; i++) begin
            set_wb(wb_order[i], 32'h40 + 32'(wb_order[i]), wb_order[i] == 3, 32'h1000);
            tick();
            checks++;
            if (commit_valid_out !== e_valid || (e_valid && commit_tag_out !== 3'(e_tag)) || flush_out !== 1'b0) begin
                errors++;
                $display("FAIL branch_pre%0d: got v=%b tag=%0d flush=%b expected v=%b tag=%0d flush=0",
                         i, commit_valid_out, commit_tag_out, flush_out, e_valid, e_tag);
            end
        end
        idle();
        set_alloc(0, 7, 32'h500);
        set_wb(4, 32'h99, 1'b0, '0);
        tick();
        idle();
        checks++;
        if (commit_valid_out !== 1'b1 || commit_tag_out !== 3'd3 || flush_out !== 1'b1 || redirect_pc_out !== 32'h1000) begin
            errors++;
            $display("FAIL branch_flush: got v=%b tag=%0d flush=%b redirect=%h expected 1 3 1 00001000",
                     commit_valid_out, commit_tag_out, flush_out, redirect_pc_out);
        end
        checks++;
        if (alloc_ready_out !== 1'b1 || alloc_tag_out !== 3'd0) begin
            errors++;
            $display("FAIL branch_empty: got ready=%b tag=%0d expected 1 0", alloc_ready_out, alloc_tag_out);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (commit_valid_out !== 1'b0 || flush_out !== 1'b0) begin
                errors++;
                $display("FAIL branch_after%0d: got v=%b flush=%b expected 0 0", i, commit_valid_out, flush_out);
            end
        end
    endtask

    task automatic test_jump();
        do_reset();
        set_alloc(2, 5, 32'h100);
        tick();
        idle();
        set_wb(0, 32'h104, 1'b1, 32'h200);
        tick();
        idle();
        tick();
        checks++;
        if (commit_valid_out !== 1'b1 || commit_reg_we_out !== 1'b1 || commit_rd_out !== 5'd5
            || commit_value_out !== 32'h104 || flush_out !== 1'b1 || redirect_pc_out !== 32'h200) begin
            errors++;
            $display("FAIL jump_commit: got v=%b we=%b rd=%0d value=%h flush=%b redirect=%h expected 1 1 5 104 1 200",
                     commit_valid_out, commit_reg_we_out, commit_rd_out, commit_value_out, flush_out, redirect_pc_out);
        end
    endtask

    task automatic test_reset_and_stall();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_alloc(0, 20 + i, 32'h600);
            tick();
        end
        idle();
        set_wb(0, 32'hAA, 1'b0, '0);
        tick();
        idle();
        tick();
        rdy_in = 1'b0;
        set_wb(1, 32'h77, 1'b0, '0);
        set_alloc(0, 30, 32'h700);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (commit_valid_out !== 1'b1 || commit_tag_out !== 3'd0 || commit_value_out !== 32'hAA || alloc_tag_out !== 3'd3) begin
                errors++;
                $display("FAIL stall_hold%0d: got v=%b tag=%0d value=%h atag=%0d expected 1 0 aa 3",
                         i, commit_valid_out, commit_tag_out, commit_value_out, alloc_tag_out);
            end
        end
        rdy_in = 1'b1;
        idle();
        tick();
        checks++;
        if (commit_valid_out !== 1'b0 || alloc_tag_out !== 3'd3) begin
            errors++;
            $display("FAIL stall_release: got v=%b atag=%0d expected 0 3", commit_valid_out, alloc_tag_out);
        end
        set_wb(1, 32'h55, 1'b0, '0);
        tick();
        idle();
        #2;
        rst_in = 1'b0;
        #1;
        model_reset();
        checks++;
        if (commit_valid_out !== 1'b0 || flush_out !== 1'b0 || commit_reg_we_out !== 1'b0 || commit_tag_out !== 3'd0
            || commit_rd_out !== 5'd0 || commit_value_out !== 32'd0 || redirect_pc_out !== 32'd0
            || alloc_ready_out !== 1'b1 || alloc_tag_out !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: got v=%b flush=%b we=%b tag=%0d rd=%0d value=%h redirect=%h ready=%b atag=%0d expected reset values",
                     commit_valid_out, flush_out, commit_reg_we_out, commit_tag_out, commit_rd_out,
                     commit_value_out, redirect_pc_out, alloc_ready_out, alloc_tag_out);
        end
        @(negedge clk_in);
        rst_in = 1'b1;
        set_wb(2, 32'h66, 1'b1, 32'h800);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (commit_valid_out !== 1'b0 || flush_out !== 1'b0) begin
                errors++;
                $display("FAIL post_reset%0d: got v=%b flush=%b expected 0 0", i, commit_valid_out, flush_out);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rdy_in = ($urandom_range(0, 9) != 0);
            alloc_valid_in = $urandom_range(0, 1) == 1;
            alloc_type_in = 2'($urandom_range(0, 3));
            alloc_rd_in = 5'($urandom_range(0, 31));
            alloc_pc_in = $urandom;
            wb_valid_in = $urandom_range(0, 1) == 1;
            wb_tag_in = 3'($urandom_range(0, 7));
            wb_value_in = $urandom;
            wb_pc_change_in = ($urandom_range(0, 7) == 0);
            wb_new_pc_in = $urandom;
            tick();
            checks++;
            if (commit_valid_out !== e_valid || flush_out !== e_flush) begin
                errors++;
                $display("FAIL rand_pulses@%0d: got v=%b flush=%b expected v=%b flush=%b", n, commit_valid_out, flush_out, e_valid, e_flush);
            end
            checks++;
            if (commit_tag_out !== 3'(e_tag) || commit_rd_out !== 5'(e_rd) || commit_value_out !== e_value || commit_reg_we_out !== e_we) begin
                errors++;
                $display("FAIL rand_commit@%0d: got tag=%0d rd=%0d value=%h we=%b expected tag=%0d rd=%0d value=%h we=%b",
                         n, commit_tag_out, commit_rd_out, commit_value_out, commit_reg_we_out, e_tag, e_rd, e_value, e_we);
            end
            checks++;
            if (redirect_pc_out !== e_redirect) begin
                errors++;
                $display("FAIL rand_redirect@%0d: got %h expected %h", n, redirect_pc_out, e_redirect);
            end
            checks++;
            if (alloc_ready_out !== (rob_q.size() < ROB_SIZE) || alloc_tag_out !== 3'(m_tail)) begin
                errors++;
                $display("FAIL rand_alloc@%0d: got ready=%b tag=%0d expected ready=%b tag=%0d",
                         n, alloc_ready_out, alloc_tag_out, rob_q.size() < ROB_SIZE, m_tail);
            end
        end
        rdy_in = 1'b1;
        idle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_ooo_writeback();
        test_full_commit_alloc();
        test_branch_flush();
        test_jump();
        test_reset_and_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
